// File: rtl/addsub_multicycle.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with a registered
// carry between chunks, valid/ready handshakes, carry/overflow/zero flags and
// optional signed saturation.
module addsub_multicycle #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned CHUNK  = 4,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e r_state;
    state_e w_state_next;

    // Operands shift right one chunk per cycle so the active chunk is always
    // the low CHUNK bits; the raw sum shifts in from the top.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_sat;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sat_val;
    logic [WIDTH-1:0] w_final;

    // Chunk adder, raw-result assembly, overflow detection and saturation
    always_comb begin
        w_accept   = in_valid && in_ready;
        w_last     = (r_cnt == LAST_CNT);
        w_a_chunk  = r_a[CHUNK-1:0];
        w_b_chunk  = r_b[CHUNK-1:0];
        w_sum      = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_acc_next = (r_acc >> CHUNK) | (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        // On the last chunk the low bits of r_a/r_b hold the operand MSBs.
        w_ovf      = (w_a_chunk[CHUNK-1] == w_b_chunk[CHUNK-1]) &&
                     (w_sum[CHUNK-1] != w_a_chunk[CHUNK-1]);
        w_sat_val  = w_a_chunk[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
        w_final    = (r_sat && w_ovf) ? w_sat_val : w_acc_next;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept)  w_state_next = StRun;
            StRun:   if (w_last)    w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default:                w_state_next = StIdle;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            StIdle:  in_ready  = 1'b1;
            StDone:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, per-chunk accumulation and final result/flag update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_sat       <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_a     <= a;
                        // Subtract as A + ~B + 1; the +1 enters as the initial carry.
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_sat   <= sat && SAT_EN;
                        r_cnt   <= '0;
                    end
                end
                StRun: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_acc   <= w_acc_next;
                    r_carry <= w_sum[CHUNK];
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result    <= w_final;
                        r_carry_out <= w_sum[CHUNK];
                        r_overflow  <= w_ovf;
                        r_zero      <= (w_final == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result   = r_result;
    assign carry    = r_carry_out;
    assign overflow = r_overflow;
    assign zero     = r_zero;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Directed bench for addsub_multicycle (WIDTH=16, CHUNK=4): vector table plus
// handshake-stall, input-change-during-RUN and reset-during-RUN sequences.
module tb_addsub_multicycle;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry;
    logic        overflow;
    logic        zero;

    logic        ns_in_ready;
    logic        ns_out_valid;
    logic [15:0] ns_result;
    logic        ns_carry;
    logic        ns_overflow;
    logic        ns_zero;

    int n_checks = 0;
    int n_errors = 0;

    addsub_multicycle #(.WIDTH(16), .CHUNK(4), .SAT_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    // Same stimulus, saturation logic not built
    addsub_multicycle #(.WIDTH(16), .CHUNK(4), .SAT_EN(1'b0)) dut_nosat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (ns_in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .sat       (sat),
        .out_valid (ns_out_valid),
        .out_ready (out_ready),
        .result    (ns_result),
        .carry     (ns_carry),
        .overflow  (ns_overflow),
        .zero      (ns_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        sat;
        logic [15:0] res;
        logic        c;
        logic        o;
        logic        z;
        logic [15:0] res_ns;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; presents one operation and returns just after the accept edge.
    task automatic do_accept(input logic [15:0] ta, input logic [15:0] tb_,
                             input logic tsub, input logic tsat);
        check("accept_in_ready", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_;
        sub      = tsub;
        sat      = tsat;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen at a negedge.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    // Called at a negedge in DONE; consumes the result and returns at the next negedge.
    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [15:0] held;

        //                 a        b        sub   sat   res      c     o     z     res_ns
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 16'h2233};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'hFFFE};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h8000};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 16'h8000};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 16'h7FFF};
        vecs[5] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[6] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 16'h0000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        sat       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_carry",     32'(carry),     32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_zero",      32'(zero),      32'd0);

        for (int i = 0; i < 8; i++) begin
            do_accept(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sat);
            wait_done(lat);
            check($sformatf("v%0d_latency", i),  32'(lat),       32'd4);
            check($sformatf("v%0d_result", i),   32'(result),    32'(vecs[i].res));
            check($sformatf("v%0d_carry", i),    32'(carry),     32'(vecs[i].c));
            check($sformatf("v%0d_overflow", i), 32'(overflow),  32'(vecs[i].o));
            check($sformatf("v%0d_zero", i),     32'(zero),      32'(vecs[i].z));
            check($sformatf("v%0d_nosat", i),    32'(ns_result), 32'(vecs[i].res_ns));
            release_out();
            check($sformatf("v%0d_ready_after", i), 32'(in_ready), 32'd1);
        end

        // Stall in DONE for 5 cycles: outputs stable, in_ready low throughout
        do_accept(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        wait_done(lat);
        held = result;
        check("stall_first_result", 32'(held), 32'h2233);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("stall%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d_in_ready", i),  32'(in_ready),  32'd0);
            check($sformatf("stall%0d_result", i),    32'(result),    32'(held));
        end
        release_out();
        check("stall_release_in_ready",  32'(in_ready),  32'd1);
        check("stall_release_out_valid", 32'(out_valid), 32'd0);

        // Operands changed (and in_valid held) during RUN must be ignored
        do_accept(16'h0005, 16'h0007, 1'b1, 1'b0);
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        sub      = 1'b0;
        sat      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(lat);
        check("run_change_latency", 32'(lat),      32'd2);
        check("run_change_result",  32'(result),  32'hFFFE);
        check("run_change_carry",   32'(carry),    32'd0);
        release_out();

        // Reset during RUN cycle 2 aborts; no valid result follows
        do_accept(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result",    32'(result),    32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("abort_idle%0d_out_valid", i), 32'(out_valid), 32'd0);
        end

        // Normal operation resumes after the abort
        do_accept(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_done(lat);
        check("post_abort_latency", 32'(lat),    32'd4);
        check("post_abort_result",  32'(result), 32'h3333);
        release_out();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/addsub_multicycle.md
Name: addsub_multicycle

Overview:
- Parametrised, multi-cycle signed/unsigned adder-subtractor. It is the next generation of the team's 4-bit ripple add/sub.
- Processes a WIDTH-bit operation CHUNK bits per clock, carrying between chunks in a register, so wide operands do not build a long combinational carry chain.
- Adds a valid/ready handshake on both sides, status flags (carry, signed overflow, zero), and an optional signed-saturation mode.
- Sits between an operand-issue stage and a result consumer in the datapath.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of CHUNK and at least 2.
- CHUNK, 4, bits added per clock. Number of chunks N = WIDTH/CHUNK.
- SAT_EN, 1, 1 builds the saturation logic. When 0, the sat input is ignored.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- sat  input  1  1 = saturate the result on signed overflow.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference.
- carry  output  1  carry out of the MSB. For subtract, 1 = no borrow (A >= B unsigned).
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  final result equals 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE; in_ready = 1; out_valid = 0; result = 0; carry = 0; overflow = 0; zero = 0; chunk counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On the edge where in_valid && in_ready: latch a into A_reg and (b XOR {WIDTH{sub}}) into B_reg. Latch sub into the carry register (this is the +1 for two's complement). Latch sat && SAT_EN. Clear the counter. Go to RUN.
- RUN:
  - in_ready = 0. a, b, sub and sat are ignored.
  - On each edge: sum chunk k = A_reg[k] + B_reg[k] + carry_reg, where k is the counter value. Write the chunk into result bits [k*CHUNK +: CHUNK]. Update carry_reg with the chunk carry out. Increment k.
  - On the edge that processes k = N-1, go to DONE and set out_valid = 1 with the final result and flags.
- Finalisation, on the same edge as the last chunk:
  - carry = carry out of bit WIDTH-1.
  - overflow = (A_reg[MSB] == B_reg[MSB]) && (raw result MSB != A_reg[MSB]). B_reg here is the already-inverted operand.
  - If the latched sat = 1 and overflow = 1: result = 0 followed by all ones (most positive value) when A_reg[MSB] = 0. Otherwise result = 1 followed by all zeros (most negative value).
  - carry and overflow always reflect the raw, unsaturated result.
  - zero is computed on the final, possibly saturated, result.
- Latency: out_valid rises N edges after the accepting edge. For N = 4, accept on edge 0 gives out_valid high after edge 4.
- DONE:
  - out_valid = 1, in_ready = 0.
  - result and flags are held stable while out_ready = 0, for an unlimited number of cycles.
  - On an edge with out_ready = 1: out_valid goes to 0 and the state goes to IDLE. in_ready is 1 in the next cycle.
  - There is no back-to-back accept in DONE. Throughput is one operation per N+2 cycles, minimum.
- Combinational paths: in_ready depends only on state. There is no combinational path from out_ready to in_ready or to any output.
- Data outputs while idle: result and flags keep their last values after the handshake. They are only meaningful while out_valid = 1.
- Reset mid-operation: rst in RUN or DONE aborts the operation and applies the reset values on that edge. No partial result is ever flagged valid.
- CHUNK = WIDTH (N = 1) is legal and gives single-cycle RUN.

Test Plan:
- Unsigned add, WIDTH=16 CHUNK=4: a=0x1234, b=0x0FFF, sub=0 -> result=0x2233, carry=0, overflow=0, zero=0. out_valid high exactly 4 edges after the accept edge.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, carry=0, overflow=0, zero=0.
- Positive overflow: a=0x7FFF, b=0x0001, sub=0. With sat=0 -> result=0x8000, overflow=1, carry=0. With sat=1 -> result=0x7FFF, overflow=1. With SAT_EN=0 and sat=1 -> result=0x8000.
- Negative overflow: a=0x8000, b=0x0001, sub=1, sat=1 -> result=0x8000, overflow=1, carry=1.
- Zero and equal operands: a=b=0x1234, sub=1 -> result=0x0000, zero=1, carry=1, overflow=0.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout. Release -> in_ready=1 on the next cycle.
  - Change a and b during RUN -> result unaffected.
  - Assert rst in RUN cycle 2 -> next cycle in_ready=1, out_valid=0, result=0.
